spk_out_buf: RTL and testbench

Spike output buffer of a PCSS node, directly downstream of the node's work controller and soma. It captures the packed (z,y,x) neuron ID of every neuron that fires during a timestep and queues it in a first-word-fall-through FIFO. It presents IDs to the node's router port over a valid/ready handshake. It drives the back-pressure flag that throttles the work controller's neuron sweep.

---
 rtl/pcss_node_pkg.sv | 24 ++
 rtl/spk_fifo.sv | 62 ++++++
 rtl/spk_out_buf.sv | 84 ++++++++
 tb/tb_spk_out_buf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pcss_node_pkg.sv
// Shared PCSS node definitions: default widths and the packed {z,y,x} spike-ID helpers.
package pcss_node_pkg;

  localparam int SW_DEF  = 24;
  localparam int NNW_DEF = 12;
  localparam int FW_DEF  = SW_DEF / 3;

  typedef struct packed {
    logic [FW_DEF-1:0] z;
    logic [FW_DEF-1:0] y;
    logic [FW_DEF-1:0] x;
  } spk_id_t;

  function automatic logic [SW_DEF-1:0] pack_spk_id(input logic [FW_DEF-1:0] z,
                                                    input logic [FW_DEF-1:0] y,
                                                    input logic [FW_DEF-1:0] x);
    return {z, y, x};
  endfunction

  function automatic spk_id_t unpack_spk_id(input logic [SW_DEF-1:0] id);
    return spk_id_t'(id);
  endfunction

endpackage

// File: rtl/spk_fifo.sv
// Generic synchronous first-word-fall-through FIFO; a push into a full FIFO is
// still accepted when a pop frees a slot in the same cycle.
module spk_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Empty FIFO presents zero rather than stale or uninitialised memory
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spk_out_buf.sv
// Spike output buffer: queues fired neuron IDs for the router, throttles the
// work controller near full, flags overflow and counts spikes per timestep.
module spk_out_buf
  import pcss_node_pkg::*;
#(
  parameter int SW        = SW_DEF,
  parameter int NNW       = NNW_DEF,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           soma_spk_vld,
  input  logic           soma_spk,
  input  logic [SW-1:0]  config_spk_out_neuid,
  output logic           spk_out_config_full,
  input  logic           step_start,
  input  logic           buf_clear,
  output logic           spk_out_vld,
  input  logic           spk_out_rdy,
  output logic [SW-1:0]  spk_out_data,
  output logic [NNW:0]   spk_cnt_last,
  output logic           spk_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AF_LEVEL  = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [NNW:0]  CNT_ONE   = {{NNW{1'b0}}, 1'b1};

  logic          push;
  logic          pop;
  logic          push_ok;
  logic [CW-1:0] count;
  logic [NNW:0]  spk_cnt;

  assign push = soma_spk_vld && soma_spk;
  assign pop  = spk_out_vld && spk_out_rdy;

  spk_fifo #(
    .W     (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (buf_clear),
    .push    (push),
    .pop     (pop),
    .din     (config_spk_out_neuid),
    .dout    (spk_out_data),
    .count   (count),
    .push_ok (push_ok)
  );

  // Output state is implied by the count: EMPTY when zero, HOLD otherwise
  assign spk_out_vld         = (count != '0);
  assign spk_out_config_full = (count >= AF_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk_ovf <= 1'b0;
    end else if (buf_clear) begin
      spk_ovf <= 1'b0;
    end else if (push && (count == FULL_LVL) && !pop) begin
      spk_ovf <= 1'b1;
    end
  end

  // A push landing on step_start belongs to the new timestep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk_cnt      <= '0;
      spk_cnt_last <= '0;
    end else if (buf_clear) begin
      spk_cnt <= '0;
    end else if (step_start) begin
      spk_cnt_last <= spk_cnt;
      spk_cnt      <= push_ok ? CNT_ONE : '0;
    end else if (push_ok && (spk_cnt != '1)) begin
      spk_cnt <= spk_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spk_out_buf.sv
// Scoreboard bench for spk_out_buf: expected IDs are queued at push time and a
// negedge monitor compares every handshaken output against the queue head.
module tb_spk_out_buf;
  import pcss_node_pkg::*;

  localparam int SW  = 24;
  localparam int NNW = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           soma_spk_vld = 1'b0;
  logic           soma_spk = 1'b0;
  logic [SW-1:0]  config_spk_out_neuid = '0;
  logic           spk_out_config_full;
  logic           step_start = 1'b0;
  logic           buf_clear = 1'b0;
  logic           spk_out_vld;
  logic           spk_out_rdy = 1'b0;
  logic [SW-1:0]  spk_out_data;
  logic [NNW:0]   spk_cnt_last;
  logic           spk_ovf;

  logic [SW-1:0]  exp_q [$];
  int             n_checks = 0;
  int             n_pass   = 0;

  spk_out_buf #(
    .SW        (SW),
    .NNW       (NNW),
    .DEPTH     (16),
    .AF_MARGIN (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .soma_spk_vld         (soma_spk_vld),
    .soma_spk             (soma_spk),
    .config_spk_out_neuid (config_spk_out_neuid),
    .spk_out_config_full  (spk_out_config_full),
    .step_start           (step_start),
    .buf_clear            (buf_clear),
    .spk_out_vld          (spk_out_vld),
    .spk_out_rdy          (spk_out_rdy),
    .spk_out_data         (spk_out_data),
    .spk_cnt_last         (spk_cnt_last),
    .spk_ovf              (spk_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one push; the ID joins the scoreboard only when it should come out
  task automatic apply_stimulus(input logic [SW-1:0] id, input bit expect_out);
    soma_spk_vld = 1'b1;
    soma_spk     = 1'b1;
    config_spk_out_neuid = id;
    if (expect_out) exp_q.push_back(id);
    tick();
    soma_spk_vld = 1'b0;
    soma_spk     = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && spk_out_vld; i++) tick();
    check_output("drain_done", {31'd0, spk_out_vld}, 32'd0);
    check_output("queue_left", exp_q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && !buf_clear && spk_out_vld && spk_out_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_out: got 0x%0h, expected no output at %0t", spk_out_data, $time);
      end else begin
        check_output("out_data", spk_out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [SW-1:0] id0;
    logic [SW-1:0] idx;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_output("rst_vld",  {31'd0, spk_out_vld}, 32'd0);
    check_output("rst_data", spk_out_data, 32'd0);
    check_output("rst_full", {31'd0, spk_out_config_full}, 32'd0);
    check_output("rst_cnt_last", spk_cnt_last, 32'd0);
    check_output("rst_ovf", {31'd0, spk_ovf}, 32'd0);

    $display("[TB] single spike");
    spk_out_rdy = 1'b1;
    apply_stimulus(pack_spk_id(8'h01, 8'h02, 8'h03), 1'b1);
    check_output("single_vld_hi", {31'd0, spk_out_vld}, 32'd1);
    check_output("single_data", spk_out_data, 32'h010203);
    tick();
    check_output("single_vld_lo", {31'd0, spk_out_vld}, 32'd0);

    $display("[TB] back-pressure");
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(pack_spk_id(8'h10, 8'h00, 8'(i)), 1'b1);
      if (i == 10) check_output("full_at_11", {31'd0, spk_out_config_full}, 32'd0);
      if (i == 11) check_output("full_at_12", {31'd0, spk_out_config_full}, 32'd1);
    end
    id0 = pack_spk_id(8'h10, 8'h00, 8'h00);
    tick();
    check_output("hold_vld", {31'd0, spk_out_vld}, 32'd1);
    check_output("hold_data", spk_out_data, id0);
    spk_out_rdy = 1'b1;
    tick();
    check_output("full_fall", {31'd0, spk_out_config_full}, 32'd0);
    wait_drain();

    $display("[TB] overflow");
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(pack_spk_id(8'h20, 8'h01, 8'(i)), i < 16);
      if (i == 15) check_output("ovf_at_16", {31'd0, spk_ovf}, 32'd0);
    end
    check_output("ovf_set", {31'd0, spk_ovf}, 32'd1);
    spk_out_rdy = 1'b1;
    wait_drain();
    check_output("ovf_sticky", {31'd0, spk_ovf}, 32'd1);
    buf_clear = 1'b1;
    tick();
    buf_clear = 1'b0;
    check_output("ovf_cleared", {31'd0, spk_ovf}, 32'd0);

    $display("[TB] full with push and pop");
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) apply_stimulus(pack_spk_id(8'h30, 8'h02, 8'(i)), 1'b1);
    spk_out_rdy = 1'b1;
    apply_stimulus(pack_spk_id(8'h3F, 8'h3F, 8'h3F), 1'b1);
    check_output("pp_no_ovf", {31'd0, spk_ovf}, 32'd0);
    check_output("pp_full", {31'd0, spk_out_config_full}, 32'd1);
    wait_drain();

    $display("[TB] step counter");
    buf_clear = 1'b1;
    tick();
    buf_clear = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(pack_spk_id(8'h40, 8'h00, 8'(i)), 1'b1);
    step_start = 1'b1;
    apply_stimulus(pack_spk_id(8'h41, 8'h00, 8'h00), 1'b1);
    step_start = 1'b0;
    check_output("cnt_last_5", spk_cnt_last, 32'd5);
    wait_drain();
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    check_output("cnt_last_1", spk_cnt_last, 32'd1);

    $display("[TB] clear");
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus(pack_spk_id(8'h50, 8'h00, 8'(i)), 1'b0);
    check_output("pre_clr_vld", {31'd0, spk_out_vld}, 32'd1);
    buf_clear = 1'b1;
    tick();
    buf_clear = 1'b0;
    check_output("clr_vld", {31'd0, spk_out_vld}, 32'd0);
    check_output("clr_data", spk_out_data, 32'd0);
    check_output("clr_ovf", {31'd0, spk_ovf}, 32'd0);
    check_output("clr_cnt_last", spk_cnt_last, 32'd1);
    spk_out_rdy = 1'b1;
    repeat (2) tick();
    check_output("clr_quiet", {31'd0, spk_out_vld}, 32'd0);

    $display("[TB] reset mid-drain");
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idx = pack_spk_id(8'h60, 8'h00, 8'(i));
      apply_stimulus(idx, 1'b1);
    end
    spk_out_rdy = 1'b1;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_output("arst_vld", {31'd0, spk_out_vld}, 32'd0);
    check_output("arst_data", spk_out_data, 32'd0);
    check_output("arst_full", {31'd0, spk_out_config_full}, 32'd0);
    check_output("arst_cnt_last", spk_cnt_last, 32'd0);
    check_output("arst_ovf", {31'd0, spk_ovf}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check_output("post_rst_vld", {31'd0, spk_out_vld}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
